// File: rtl/rope_controller_if.sv
// Bundles the harpoon rope request inputs and the rope geometry/hit outputs.
// The master side (game logic) drives requests; the slave side (rope_controller) drives rope state.
interface rope_controller_if;
    logic        startOfFrame;
    logic        gameActive;
    logic        ropeDeploy;
    logic [10:0] ropeXIn;
    logic        col_rope_ball;
    logic        ropeActive;
    logic [10:0] ropeX;
    logic [10:0] ropeTopY;
    logic        ropeHitBall;

    modport master (
        output startOfFrame, gameActive, ropeDeploy, ropeXIn, col_rope_ball,
        input  ropeActive, ropeX, ropeTopY, ropeHitBall
    );

    modport slave (
        input  startOfFrame, gameActive, ropeDeploy, ropeXIn, col_rope_ball,
        output ropeActive, ropeX, ropeTopY, ropeHitBall
    );
endinterface

// File: rtl/rope_controller.sv
// Harpoon rope animator: launches on a deploy press, grows one step per frame, holds at the ceiling, retires on hit.
// Latency: all outputs registered, updated on the same edge as the state. Backpressure: none, inputs sampled every cycle.
module rope_controller #(
    parameter logic [10:0] FLOOR_Y     = 11'd440,
    parameter logic [10:0] CEILING_Y   = 11'd16,
    parameter logic [10:0] GROW_STEP   = 11'd4,
    parameter logic [5:0]  HOLD_FRAMES = 6'd30
) (
    input logic         clk,
    input logic         resetN,
    rope_controller_if.slave rope
);
    typedef enum logic [1:0] {IDLE, EXTEND, HOLD} state_t;

    state_t      state, state_n;
    logic [10:0] top_n, x_n;
    logic [5:0]  hold_cnt, hold_n;
    logic        armed, armed_n, hit_n;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state            <= IDLE;
            rope.ropeActive  <= 1'b0;
            rope.ropeX       <= 11'd0;
            rope.ropeTopY    <= FLOOR_Y;
            rope.ropeHitBall <= 1'b0;
            hold_cnt         <= 6'd0;
            armed            <= 1'b1;
        end else begin
            state            <= state_n;
            rope.ropeActive  <= (state_n != IDLE);
            rope.ropeX       <= x_n;
            rope.ropeTopY    <= top_n;
            rope.ropeHitBall <= hit_n;
            hold_cnt         <= hold_n;
            armed            <= armed_n;
        end
    end

    always_comb begin
        state_n = state;
        top_n   = rope.ropeTopY;
        x_n     = rope.ropeX;
        hold_n  = hold_cnt;
        armed_n = armed;
        hit_n   = 1'b0;

        // Leaving play mode parks the rope silently and keeps the arm latch as is.
        if (!rope.gameActive) begin
            state_n = IDLE;
            top_n   = FLOOR_Y;
        end else begin
            case (state)
                IDLE: begin
                    top_n = FLOOR_Y;
                    if (!rope.ropeDeploy) begin
                        armed_n = 1'b1;
                    end else if (armed) begin
                        x_n     = rope.ropeXIn;
                        armed_n = 1'b0;
                        state_n = EXTEND;
                    end
                end
                EXTEND: begin
                    if (rope.col_rope_ball) begin
                        hit_n   = 1'b1;
                        state_n = IDLE;
                        top_n   = FLOOR_Y;
                    end else if (rope.startOfFrame) begin
                        // Compare before subtracting so the top never crosses the ceiling or wraps.
                        if (rope.ropeTopY >= CEILING_Y + GROW_STEP + 11'd1) begin
                            top_n = rope.ropeTopY - GROW_STEP;
                        end else begin
                            top_n   = CEILING_Y;
                            hold_n  = 6'd0;
                            state_n = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (rope.col_rope_ball) begin
                        hit_n   = 1'b1;
                        state_n = IDLE;
                        top_n   = FLOOR_Y;
                    end else if (rope.startOfFrame) begin
                        if (hold_cnt == HOLD_FRAMES) begin
                            state_n = IDLE;
                            top_n   = FLOOR_Y;
                        end else begin
                            hold_n = hold_cnt + 6'd1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    top_n   = FLOOR_Y;
                end
            endcase
        end
    end
endmodule
